// File: rtl/parking_system.sv
// parking_system: entrance-sensor gate controller with 2-digit password, LEDs and 7-segment status.
// Optional timeout out of WRONG_PASS/STOP back to IDLE when PARKING_TIMEOUT_EN is defined.
module parking_system #(
  parameter int         WAIT_CYCLES = 4,
  parameter logic [1:0] PASS_1      = 2'b01,
  parameter logic [1:0] PASS_2      = 2'b10
`ifdef PARKING_TIMEOUT_EN
  , parameter int       TIMEOUT_CYCLES = 64
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor_entrance,
  input  logic       sensor_exit,
  input  logic [1:0] password_1,
  input  logic [1:0] password_2,
  output logic       GREEN_LED,
  output logic       RED_LED,
  output logic [6:0] HEX_1,
  output logic [6:0] HEX_2
);
  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WAIT_PASSWORD = 3'd1,
    WRONG_PASS    = 3'd2,
    RIGHT_PASS    = 3'd3,
    STOP          = 3'd4
  } state_t;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  state_t      state;
  logic [31:0] cnt;
  logic        blink;
  logic        pass_ok;
  logic        timeout;
  assign pass_ok = (password_1 == PASS_1) && (password_2 == PASS_2);
`ifdef PARKING_TIMEOUT_EN
  logic [31:0] tcnt;
  assign timeout = tcnt >= 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) tcnt <= '0;
    else tcnt <= (state == WRONG_PASS || state == STOP) ? tcnt + 32'd1 : '0;
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      blink     <= 1'b0;
      GREEN_LED <= 1'b0;
      RED_LED   <= 1'b0;
      HEX_1     <= SEG_BLANK;
      HEX_2     <= SEG_BLANK;
    end else begin
      blink <= ~blink;
      cnt   <= (state == WAIT_PASSWORD) ? cnt + 32'd1 : '0;
      case (state)
        IDLE:          state <= sensor_entrance ? WAIT_PASSWORD : IDLE;
        WAIT_PASSWORD: state <= (cnt < 32'(WAIT_CYCLES)) ? WAIT_PASSWORD : pass_ok ? RIGHT_PASS : WRONG_PASS;
        WRONG_PASS:    state <= pass_ok ? RIGHT_PASS : timeout ? IDLE : WRONG_PASS;
        RIGHT_PASS:    state <= (sensor_entrance && sensor_exit) ? STOP : sensor_exit ? IDLE : RIGHT_PASS;
        STOP:          state <= pass_ok ? RIGHT_PASS : timeout ? IDLE : STOP;
        default:       state <= IDLE;
      endcase
      // outputs follow the pre-edge state, so they trail it by one cycle
      case (state)
        WAIT_PASSWORD: begin GREEN_LED <= 1'b0;  RED_LED <= 1'b1;  HEX_1 <= SEG_E; HEX_2 <= SEG_N; end
        WRONG_PASS:    begin GREEN_LED <= 1'b0;  RED_LED <= blink; HEX_1 <= SEG_E; HEX_2 <= SEG_E; end
        RIGHT_PASS:    begin GREEN_LED <= blink; RED_LED <= 1'b0;  HEX_1 <= SEG_6; HEX_2 <= SEG_0; end
        STOP:          begin GREEN_LED <= 1'b0;  RED_LED <= blink; HEX_1 <= SEG_S; HEX_2 <= SEG_P; end
        default:       begin GREEN_LED <= 1'b0;  RED_LED <= 1'b0;  HEX_1 <= SEG_BLANK; HEX_2 <= SEG_BLANK; end
      endcase
    end
  end
endmodule

// File: tb/tb_parking_system.sv
// tb_parking_system: directed plus random stimulus against a cycle-level reference model of the gate rules.
module tb_parking_system;
  localparam int WAIT_CYCLES = 4;
  localparam int TIMEOUT_CYCLES = 64;
  localparam logic [6:0] BL = 7'b1111111;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sensor_entrance = 1'b0, sensor_exit = 1'b0;
  logic [1:0] password_1 = 2'd0, password_2 = 2'd0;
  logic GREEN_LED, RED_LED;
  logic [6:0] HEX_1, HEX_2;
  int vectors = 0, miscompares = 0;
  string m_st = "IDLE";
  int m_age = 0;
  bit m_blink = 1'b0;
  logic [15:0] m_out = {2'b00, BL, BL};

  parking_system dut (
    .clk(clk), .reset_n(reset_n), .sensor_entrance(sensor_entrance), .sensor_exit(sensor_exit),
    .password_1(password_1), .password_2(password_2),
    .GREEN_LED(GREEN_LED), .RED_LED(RED_LED), .HEX_1(HEX_1), .HEX_2(HEX_2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h (model state %s) t=%0t", tag, got, exp, m_st, $time);
    end
  endtask

  function automatic logic [15:0] decode(input string s, input bit b);
    case (s)
      "WAIT":  return {1'b0, 1'b1, 7'b0000110, 7'b0101011};
      "WRONG": return {1'b0, b,    7'b0000110, 7'b0000110};
      "RIGHT": return {b,    1'b0, 7'b0000010, 7'b1000000};
      "STOP":  return {1'b0, b,    7'b0010010, 7'b0001100};
      default: return {2'b00, BL, BL};
    endcase
  endfunction

  task automatic model_step();
    bit ok = (password_1 == 2'b01) && (password_2 == 2'b10);
    bit to = 1'b0;
    string nx = m_st;
`ifdef PARKING_TIMEOUT_EN
    to = (m_age >= TIMEOUT_CYCLES - 1);
`endif
    m_out = decode(m_st, m_blink);
    m_blink = ~m_blink;
    case (m_st)
      "IDLE":  if (sensor_entrance) nx = "WAIT";
      "WAIT":  if (m_age >= WAIT_CYCLES) nx = ok ? "RIGHT" : "WRONG";
      "WRONG": nx = ok ? "RIGHT" : to ? "IDLE" : "WRONG";
      "RIGHT": nx = (sensor_entrance && sensor_exit) ? "STOP" : sensor_exit ? "IDLE" : "RIGHT";
      "STOP":  nx = ok ? "RIGHT" : to ? "IDLE" : "STOP";
      default: nx = "IDLE";
    endcase
    m_age = (nx == m_st) ? m_age + 1 : 0;
    m_st = nx;
  endtask

  task automatic compare_all();
    check("green", 32'(GREEN_LED), 32'(m_out[15]));
    check("red",   32'(RED_LED),   32'(m_out[14]));
    check("hex1",  32'(HEX_1),     32'(m_out[13:7]));
    check("hex2",  32'(HEX_2),     32'(m_out[6:0]));
  endtask

  task automatic step(input bit e, input bit x, input logic [1:0] p1, input logic [1:0] p2);
    sensor_entrance = e; sensor_exit = x; password_1 = p1; password_2 = p2;
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic async_reset(input int cycles, input int offset);
    #(offset);
    reset_n = 1'b0;
    #1;
    check("rst_green", 32'(GREEN_LED), 32'd0);
    check("rst_red",   32'(RED_LED),   32'd0);
    check("rst_hex1",  32'(HEX_1),     32'(BL));
    check("rst_hex2",  32'(HEX_2),     32'(BL));
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_st = "IDLE"; m_age = 0; m_blink = 1'b0; m_out = {2'b00, BL, BL};
    compare_all();
  endtask

  initial begin
    @(negedge clk);
    async_reset(5, 0);
    // wrong password: wait window then EE with blinking red
    for (int i = 0; i < 14; i++) step(1, 0, 2'd0, 2'd0);
    check("wrong_hex2", 32'(HEX_2), 32'(7'b0000110));
    for (int i = 0; i < 3; i++) step(0, 0, 2'd1, 2'd2);
    check("right_hex1", 32'(HEX_1), 32'(7'b0000010));
    for (int i = 0; i < 2; i++) step(0, 1, 2'd1, 2'd2);
    for (int i = 0; i < 3; i++) step(0, 0, 2'd0, 2'd0);
    check("idle_hex1", 32'(HEX_1), 32'(BL));
    // password changes during countdown: only the final value counts
    step(1, 0, 2'd1, 2'd2);
    for (int i = 0; i < 3; i++) step(0, 0, 2'd1, 2'd2);
    for (int i = 0; i < 4; i++) step(0, 0, 2'd3, 2'd2);
    // tailgate then recovery
    for (int i = 0; i < 3; i++) step(0, 0, 2'd1, 2'd2);
    for (int i = 0; i < 3; i++) step(1, 1, 2'd0, 2'd0);
    check("stop_hex2", 32'(HEX_2), 32'(7'b0001100));
    for (int i = 0; i < 3; i++) step(0, 0, 2'd1, 2'd2);
    async_reset(2, 2);
    // long wrong hold exercises the optional timeout when built in
    for (int i = 0; i < TIMEOUT_CYCLES + 10; i++) step(i == 0, 0, 2'd2, 2'd1);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset($urandom_range(1, 3), $urandom_range(0, 3));
      else if ($urandom_range(0, 3) == 0)
        step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 2'd1, 2'd2);
      else
        step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 2'($urandom), 2'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
